dist_sq_gen: RTL and testbench

Upstream feeder for the beamforming square-root stage (`sqrt` / `sqrt_nr`). For one focal point (px, pz), the block walks a linear transducer array of N_ELEM elements and emits the 32-bit squared distance (px − ex)² + pz² for each element, one at a time. Results go out over a valid/ready handshake so the iterative sqrt can pace the stream. The block has one clock, an enable-gated FSM, and a debug state output in the same style as the sqrt cores.

---
 rtl/dist_sq_gen_if.sv | 12 +
 rtl/dist_sq_gen.sv | 127 ++++++++++++
 tb/tb_dist_sq_gen.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dist_sq_gen_if.sv
// rtl/dist_sq_gen_if.sv - result stream bundle between dist_sq_gen and its consumer
// Carries one squared distance per handshake, tagged with its element index.
interface dist_sq_gen_if;
   logic [31:0] dout;
   logic        valid;
   logic        ready;
   logic [9:0]  elem_idx;
   logic        last;

   modport master (output dout, output valid, output elem_idx, output last, input ready);
   modport slave  (input dout, input valid, input elem_idx, input last, output ready);
endinterface

// File: rtl/dist_sq_gen.sv
// rtl/dist_sq_gen.sv - squared focal distance generator for a linear transducer array
// Walks N_ELEM elements for one latched focal point and streams (px-ex)^2 + pz^2 per element.
module dist_sq_gen #(
   parameter int N_ELEM = 64,
   parameter int X0     = -2016,
   parameter int PITCH  = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               start,
   input  logic signed [11:0] px,
   input  logic signed [11:0] pz,
   dist_sq_gen_if.master      bus,
   output logic               busy,
   output logic               done,
   output logic [3:0]         cstate
);

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      DIFF = 4'd2,
      SQR  = 4'd3,
      OUT  = 4'd4,
      DONE = 4'd5
   } state_t;

   state_t             state_q;
   logic signed [11:0] px_q;
   logic signed [11:0] pz_q;
   logic signed [12:0] ex_q;
   logic signed [12:0] dx_q;
   logic [31:0]        dout_q;
   logic               valid_q;
   logic               last_q;
   logic [9:0]         elem_idx_q;
   logic               done_q;

   logic signed [12:0] px_ext;
   logic signed [12:0] dx_d;
   logic signed [24:0] dx_ext;
   logic signed [23:0] pz_ext;
   logic [24:0]        dx_sq_d;
   logic [23:0]        pz_sq_d;
   logic [24:0]        sum_d;

   // dx^2 fits in 25 bits and is non-negative, so the wrapped 25-bit product is exact
   always_comb begin
      px_ext  = 13'(px_q);
      dx_d    = px_ext - ex_q;
      dx_ext  = 25'(dx_q);
      pz_ext  = 24'(pz_q);
      dx_sq_d = dx_ext * dx_ext;
      pz_sq_d = pz_ext * pz_ext;
      sum_d   = dx_sq_d + {1'b0, pz_sq_d};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         px_q       <= '0;
         pz_q       <= '0;
         ex_q       <= '0;
         dx_q       <= '0;
         dout_q     <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         elem_idx_q <= '0;
         done_q     <= 1'b0;
      end else if (enable) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  px_q       <= px;
                  pz_q       <= pz;
                  ex_q       <= 13'(X0);
                  elem_idx_q <= '0;
                  state_q    <= DIFF;
               end
            end
            DIFF: begin
               dx_q    <= dx_d;
               state_q <= SQR;
            end
            SQR: begin
               dout_q  <= {7'd0, sum_d};
               valid_q <= 1'b1;
               last_q  <= (elem_idx_q == 10'(N_ELEM - 1));
               state_q <= OUT;
            end
            OUT: begin
               if (valid_q && bus.ready) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  if (last_q) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     elem_idx_q <= elem_idx_q + 10'd1;
                     ex_q       <= ex_q + 13'(PITCH);
                     state_q    <= DIFF;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.dout     = dout_q;
   assign bus.valid    = valid_q;
   assign bus.elem_idx = elem_idx_q;
   assign bus.last     = last_q;
   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign cstate       = state_q;

endmodule

// File: tb/tb_dist_sq_gen.sv
// tb/tb_dist_sq_gen.sv - directed bench for dist_sq_gen
// A 4-element array instance covers sweeps and control; a 1-element instance covers widths.
module tb_dist_sq_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset, enable, start, start2;
   logic signed [11:0] px, pz;
   logic               busy, done, busy2, done2;
   logic [3:0]         cstate, cstate2;

   dist_sq_gen_if bus ();
   dist_sq_gen_if bus2 ();

   dist_sq_gen #(.N_ELEM(4), .X0(-96), .PITCH(64)) dut (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .px(px), .pz(pz),
      .bus(bus), .busy(busy), .done(done), .cstate(cstate)
   );

   dist_sq_gen #(.N_ELEM(1), .X0(2047), .PITCH(64)) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .start(start2), .px(px), .pz(pz),
      .bus(bus2), .busy(busy2), .done(done2), .cstate(cstate2)
   );

   int total = 0;
   int bad   = 0;

   // (0 - ex)^2 + 100^2 for ex = -96, -32, 32, 96
   logic [31:0] exp_dout [4] = '{32'd19216, 32'd11024, 32'd11024, 32'd19216};

   logic [31:0] got_dout [8];
   logic [9:0]  got_idx  [8];
   logic        got_last [8];
   int          n_got, done_t, done_len, first_valid_t, hold_bad, frz_bad;
   int          ed_hits, eo_hits;
   bit          timed_out, stray_done, rst_hit;
   logic        end_busy;
   logic [3:0]  end_cs;

   // Drives one frame on dut starting at the current negedge and records what it observes.
   task automatic frame(input logic signed [11:0] fpx, input logic signed [11:0] fpz,
                        input int bp_elem, input int bp_len, input int en_len,
                        input bit stray, input int rst_elem);
      int t, bp_cnt;
      bit en_low_prev, holding;
      logic [3:0]  cs_prev;
      logic [31:0] hold_dout;
      logic [9:0]  hold_idx;
      n_got = 0; done_t = -1; done_len = 0; first_valid_t = -1; hold_bad = 0; frz_bad = 0;
      ed_hits = 0; eo_hits = 0; timed_out = 0; stray_done = 0; rst_hit = 0;
      bp_cnt = 0; en_low_prev = 0; holding = 0; cs_prev = 4'd0;
      hold_dout = '0; hold_idx = '0;
      px = fpx; pz = fpz; start = 1'b1; bus.ready = 1'b1; enable = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (t < 200) begin
         if (en_low_prev && cstate !== cs_prev) frz_bad++;
         if (holding && (bus.dout !== hold_dout || bus.elem_idx !== hold_idx || bus.valid !== 1'b1))
            hold_bad++;
         if (bus.valid === 1'b1 && first_valid_t < 0) first_valid_t = t;
         if (done === 1'b1) begin
            if (done_t < 0) done_t = t;
            done_len++;
         end else if (done_t >= 0) begin
            break;
         end
         start = 1'b0; bus.ready = 1'b1; enable = 1'b1; holding = 0; en_low_prev = 0;
         if (rst_elem >= 0 && cstate == 4'd4 && bus.elem_idx == 10'(rst_elem)) begin
            reset = 1'b0;
            rst_hit = 1;
         end
         if (bp_elem >= 0 && cstate == 4'd4 && bus.elem_idx == 10'(bp_elem) && bp_cnt < bp_len) begin
            bus.ready = 1'b0; bp_cnt++; holding = 1;
            hold_dout = bus.dout; hold_idx = bus.elem_idx;
         end
         if (en_len > 0 && bus.elem_idx == 10'd1 && cstate == 4'd2 && ed_hits < en_len) begin
            enable = 1'b0; ed_hits++;
         end
         if (en_len > 0 && bus.elem_idx == 10'd1 && cstate == 4'd4 && eo_hits < en_len) begin
            enable = 1'b0; eo_hits++;
         end
         if (stray && !stray_done && cstate == 4'd3 && bus.elem_idx == 10'd1) begin
            start = 1'b1; px = 12'sd500; stray_done = 1;
         end
         if (!enable) begin
            en_low_prev = 1; cs_prev = cstate;
         end
         if (reset && bus.valid && bus.ready && enable && n_got < 8) begin
            got_dout[n_got] = bus.dout;
            got_idx[n_got]  = bus.elem_idx;
            got_last[n_got] = bus.last;
            n_got++;
         end
         @(negedge clk);
         if (rst_hit) begin
            reset = 1'b1;
            break;
         end
         t++;
      end
      if (t >= 200) timed_out = 1;
      end_busy = busy;
      end_cs = cstate;
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1; start = 1'b0; start2 = 1'b0;
      px = '0; pz = '0; bus.ready = 1'b0; bus2.ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      total++; if (bus.dout !== 32'd0) begin bad++; $display("FAIL reset_dout got=%0d want=0", bus.dout); end
      total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
      total++; if (bus.elem_idx !== 10'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", bus.elem_idx); end
      total++; if (bus.last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", bus.last); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (cstate !== 4'd0) begin bad++; $display("FAIL reset_cstate got=%0d want=0", cstate); end
      total++; if (bus2.valid !== 1'b0) begin bad++; $display("FAIL reset_valid2 got=%b want=0", bus2.valid); end
   endtask

   task automatic test_basic();
      frame(12'sd0, 12'sd100, -1, 0, 0, 0, -1);
      total++; if (timed_out) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
      total++; if (n_got !== 4) begin bad++; $display("FAIL basic_count got=%0d want=4", n_got); end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (got_dout[k] !== exp_dout[k] || got_idx[k] !== 10'(k) || got_last[k] !== (k == 3)) begin
            bad++;
            $display("FAIL basic_elem%0d got=%0d/%0d/%b want=%0d/%0d/%b", k,
                     got_dout[k], got_idx[k], got_last[k], exp_dout[k], k, (k == 3));
         end
      end
      total++; if (first_valid_t !== 2) begin bad++; $display("FAIL basic_latency got=%0d want=2", first_valid_t); end
      total++; if (done_t !== 12) begin bad++; $display("FAIL basic_done_time got=%0d want=12", done_t); end
      total++; if (done_len !== 1) begin bad++; $display("FAIL basic_done_len got=%0d want=1", done_len); end
      total++; if (end_busy !== 1'b0 || end_cs !== 4'd0) begin
         bad++; $display("FAIL basic_idle_after got=%b/%0d want=0/0", end_busy, end_cs);
      end
   endtask

   task automatic test_extreme();
      int w;
      bit seen;
      px = -12'sd2048; pz = -12'sd2048; start2 = 1'b1; bus2.ready = 1'b0;
      @(negedge clk);
      start2 = 1'b0;
      seen = 0;
      for (w = 0; w < 10 && !seen; w++) begin
         if (bus2.valid === 1'b1) seen = 1;
         else @(negedge clk);
      end
      total++; if (!seen) begin bad++; $display("FAIL ext_valid got=0 want=1"); end
      total++; if (bus2.dout !== 32'h013FE001) begin bad++; $display("FAIL ext_dout got=%h want=013fe001", bus2.dout); end
      total++; if (bus2.dout[31:25] !== 7'd0) begin bad++; $display("FAIL ext_upper got=%h want=0", bus2.dout[31:25]); end
      total++; if (bus2.last !== 1'b1 || bus2.elem_idx !== 10'd0) begin
         bad++; $display("FAIL ext_last got=%b/%0d want=1/0", bus2.last, bus2.elem_idx);
      end
      bus2.ready = 1'b1;
      @(negedge clk);
      bus2.ready = 1'b0;
      total++; if (done2 !== 1'b1 || bus2.valid !== 1'b0) begin
         bad++; $display("FAIL ext_done got=%b/%b want=1/0", done2, bus2.valid);
      end
      @(negedge clk);
      px = '0; pz = '0;
   endtask

   task automatic test_backpressure();
      frame(12'sd0, 12'sd100, 1, 5, 0, 0, -1);
      total++; if (n_got !== 4) begin bad++; $display("FAIL bp_count got=%0d want=4", n_got); end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (got_dout[k] !== exp_dout[k] || got_idx[k] !== 10'(k)) begin
            bad++; $display("FAIL bp_elem%0d got=%0d/%0d want=%0d/%0d", k, got_dout[k], got_idx[k], exp_dout[k], k);
         end
      end
      total++; if (hold_bad !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", hold_bad); end
      total++; if (done_t !== 17) begin bad++; $display("FAIL bp_done_time got=%0d want=17", done_t); end
   endtask

   task automatic test_enable();
      frame(12'sd0, 12'sd100, -1, 0, 3, 0, -1);
      total++; if (n_got !== 4) begin bad++; $display("FAIL en_count got=%0d want=4", n_got); end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (got_dout[k] !== exp_dout[k] || got_idx[k] !== 10'(k)) begin
            bad++; $display("FAIL en_elem%0d got=%0d/%0d want=%0d/%0d", k, got_dout[k], got_idx[k], exp_dout[k], k);
         end
      end
      total++; if (ed_hits !== 3 || eo_hits !== 3) begin
         bad++; $display("FAIL en_windows got=%0d/%0d want=3/3", ed_hits, eo_hits);
      end
      total++; if (frz_bad !== 0) begin bad++; $display("FAIL en_frozen got=%0d want=0", frz_bad); end
      total++; if (done_t !== 18) begin bad++; $display("FAIL en_done_time got=%0d want=18", done_t); end
   endtask

   task automatic test_stray();
      frame(12'sd0, 12'sd100, -1, 0, 0, 1, -1);
      total++; if (!stray_done) begin bad++; $display("FAIL stray_applied got=0 want=1"); end
      total++; if (n_got !== 4) begin bad++; $display("FAIL stray_count got=%0d want=4", n_got); end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (got_dout[k] !== exp_dout[k] || got_idx[k] !== 10'(k)) begin
            bad++; $display("FAIL stray_elem%0d got=%0d/%0d want=%0d/%0d", k, got_dout[k], got_idx[k], exp_dout[k], k);
         end
      end
      total++; if (done_t !== 12) begin bad++; $display("FAIL stray_done_time got=%0d want=12", done_t); end
   endtask

   task automatic test_reset_mid();
      frame(12'sd0, 12'sd100, -1, 0, 0, 0, 2);
      total++; if (!rst_hit) begin bad++; $display("FAIL rmid_hit got=0 want=1"); end
      total++; if (n_got !== 2) begin bad++; $display("FAIL rmid_count got=%0d want=2", n_got); end
      total++;
      if (bus.dout !== 32'd0 || bus.valid !== 1'b0 || bus.elem_idx !== 10'd0 || bus.last !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0 || cstate !== 4'd0) begin
         bad++;
         $display("FAIL rmid_outputs got=%0d/%b/%0d/%b/%b/%b/%0d want=0/0/0/0/0/0/0",
                  bus.dout, bus.valid, bus.elem_idx, bus.last, busy, done, cstate);
      end
      total++; if (done_len !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", done_len); end
      frame(12'sd0, 12'sd100, -1, 0, 0, 0, -1);
      total++; if (n_got !== 4) begin bad++; $display("FAIL rmid_restart_count got=%0d want=4", n_got); end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (got_dout[k] !== exp_dout[k] || got_idx[k] !== 10'(k)) begin
            bad++; $display("FAIL rmid_elem%0d got=%0d/%0d want=%0d/%0d", k, got_dout[k], got_idx[k], exp_dout[k], k);
         end
      end
      total++; if (done_t !== 12) begin bad++; $display("FAIL rmid_done_time got=%0d want=12", done_t); end
   endtask

   task automatic test_back_to_back();
      frame(12'sd0, 12'sd100, -1, 0, 0, 0, -1);
      frame(12'sd32, 12'sd100, -1, 0, 0, 0, -1);
      // px=32: dx = 128, 64, 0, -64
      total++; if (n_got !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", n_got); end
      total++; if (got_dout[0] !== 32'd26384) begin bad++; $display("FAIL b2b_elem0 got=%0d want=26384", got_dout[0]); end
      total++; if (got_dout[1] !== 32'd14096) begin bad++; $display("FAIL b2b_elem1 got=%0d want=14096", got_dout[1]); end
      total++; if (got_dout[2] !== 32'd10000) begin bad++; $display("FAIL b2b_elem2 got=%0d want=10000", got_dout[2]); end
      total++; if (got_dout[3] !== 32'd14096 || got_last[3] !== 1'b1) begin
         bad++; $display("FAIL b2b_elem3 got=%0d/%b want=14096/1", got_dout[3], got_last[3]);
      end
      total++; if (first_valid_t !== 2 || done_t !== 12) begin
         bad++; $display("FAIL b2b_timing got=%0d/%0d want=2/12", first_valid_t, done_t);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extreme();
      test_backpressure();
      test_enable();
      test_stray();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
endmodule
